// File: rtl/stepper_pkg.sv
// Shared types, constants and helpers for the stepper_multi button/address slice.
package stepper_pkg;

  // Per-channel debounce states.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounce_state_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

  // Bits needed to hold any value in 0..max_val (never less than one).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One push-button channel: 2-FF synchroniser, debounce FSM and a registered
// one-cycle press pulse. Optional auto-repeat while held is enabled by
// defining STEPPER_MULTI_AUTO_REPEAT_EN.
module btn_conditioner
  import stepper_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned REPEAT_CYCLES   = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);

  localparam logic [1:0] ST_IDLE         = IDLE;
  localparam logic [1:0] ST_PRESS_WAIT   = PRESS_WAIT;
  localparam logic [1:0] ST_HELD         = HELD;
  localparam logic [1:0] ST_RELEASE_WAIT = RELEASE_WAIT;

  logic            sync_meta, sync_q;
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            deb_press;
  logic            press_q, press_d;

  // Two-flop synchroniser for the raw asynchronous button.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_q    <= sync_meta;
    end
  end

  // Debounce next-state: a level change is accepted only after a full stable run.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    deb_press = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync_q) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CntW'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
          state_d   = ST_HELD;
          deb_press = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!sync_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CntW'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        // Bounce back to HELD never produces a second press.
        if (sync_q) begin
          state_d = ST_HELD;
        end else if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Debounce state and run counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STEPPER_MULTI_AUTO_REPEAT_EN
  localparam int unsigned HoldMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HoldW   = cnt_width(HoldMax);

  logic [HoldW-1:0] hold_q, hold_d, hold_inc, hold_target;
  logic             repeating_q, repeating_d;
  logic             rep_press;

  // Hold counter runs only while staying in HELD; first gap is HOLD, then REPEAT.
  always_comb begin
    hold_d      = '0;
    repeating_d = 1'b0;
    rep_press   = 1'b0;
    hold_inc    = hold_q + 1'b1;
    hold_target = repeating_q ? HoldW'(REPEAT_CYCLES) : HoldW'(HOLD_CYCLES);
    if (state_q == ST_HELD && state_d == ST_HELD) begin
      if (hold_inc == hold_target) begin
        rep_press   = 1'b1;
        repeating_d = 1'b1;
      end else begin
        hold_d      = hold_inc;
        repeating_d = repeating_q;
      end
    end
  end

  // Auto-repeat counter state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q      <= '0;
      repeating_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      repeating_q <= repeating_d;
    end
  end

  assign press_d = deb_press | rep_press;
`else
  logic unused_cfg;
  assign unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};
  assign press_d    = deb_press;
`endif

  // Registered one-cycle press pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      press_q <= 1'b0;
    end else begin
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stepper_multi.sv
// Bounded up/down address stepper driven by two debounced push-buttons, with
// synchronous load and wrap or saturate behaviour at the limits. Auto-repeat
// of held buttons is enabled by defining STEPPER_MULTI_AUTO_REPEAT_EN.
module stepper_multi
  import stepper_pkg::*;
#(
  parameter int unsigned ADDR_W          = 3,
  parameter int unsigned ADDR_MAX        = 7,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned WRAP            = 1,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned REPEAT_CYCLES   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              step_up,
  input  logic              step_down,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  output logic [ADDR_W-1:0] address,
  output logic              step_pulse,
  output logic              at_limit
);

  localparam logic [ADDR_W-1:0] AddrMax = ADDR_W'(ADDR_MAX);

  logic              up_press, down_press;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              step_q, step_d;
  logic              limit_q, limit_d;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_up (
    .clock (clock),
    .reset (reset),
    .btn   (step_up),
    .press (up_press)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_down (
    .clock (clock),
    .reset (reset),
    .btn   (step_down),
    .press (down_press)
  );

  // Arbitration: load wins, simultaneous presses cancel, else a single step.
  always_comb begin
    addr_d  = addr_q;
    limit_d = 1'b0;
    if (load) begin
      addr_d = (load_value > AddrMax) ? AddrMax : load_value;
    end else if (up_press ^ down_press) begin
      if (up_press) begin
        if (addr_q < AddrMax) begin
          addr_d = addr_q + 1'b1;
        end else if (WRAP != 0) begin
          addr_d = '0;
        end else begin
          limit_d = 1'b1;
        end
      end else begin
        if (addr_q != '0) begin
          addr_d = addr_q - 1'b1;
        end else if (WRAP != 0) begin
          addr_d = AddrMax;
        end else begin
          limit_d = 1'b1;
        end
      end
    end
    step_d = (addr_d != addr_q);
  end

  // Address and status flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      step_q  <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      step_q  <= step_d;
      limit_q <= limit_d;
    end
  end

  assign address    = addr_q;
  assign step_pulse = step_q;
  assign at_limit   = limit_q;

endmodule
